// File: rtl/aux_int_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : aux_int_input_conditioner
// Brief    : Synchronises, debounces and edge-detects board interrupt inputs,
//            latching per-channel pending requests acknowledged by ID.
// Revision : 1.0 - initial release
// ============================================================================
module aux_int_input_conditioner #(
  parameter int NUM_IN       = 3,
  parameter int ID_BIT       = 2,
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int CNT_BIT      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] raw_in,
  input  logic [NUM_IN-1:0] mask,
  input  logic              int_ack,
  input  logic [ID_BIT-1:0] int_ack_id,
  output logic [NUM_IN-1:0] level,
  output logic [NUM_IN-1:0] rise_pulse,
  output logic [NUM_IN-1:0] int_pending,
  output logic [NUM_IN-1:0] int_overrun,
  output logic              int_req,
  output logic [ID_BIT-1:0] int_id
);

  localparam logic [CNT_BIT-1:0] c_cnt_last = CNT_BIT'(DEBOUNCE_CNT - 1);

  logic [NUM_IN-1:0]  r_s1;
  logic [NUM_IN-1:0]  r_s2;
  logic [NUM_IN-1:0]  r_level;
  logic [NUM_IN-1:0]  r_rise;
  logic [NUM_IN-1:0]  r_pending;
  logic [NUM_IN-1:0]  r_overrun;
  logic [CNT_BIT-1:0] r_cnt [NUM_IN];
  logic [NUM_IN-1:0]  w_clr;
  logic [NUM_IN-1:0]  w_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CNT consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_rise  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        r_rise[i] <= 1'b0;
        if (r_s2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_cnt_last) begin
          r_level[i] <= r_s2[i];
          r_rise[i]  <= r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_BIT'(1);
        end
      end
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_clr[i] = int_ack && (int_ack_id == ID_BIT'(i));
    end
  end

  // A new edge beats a simultaneous ack so the fresh request is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_rise[i]) begin
          r_pending[i] <= 1'b1;
          if (r_pending[i] && !w_clr[i]) begin
            r_overrun[i] <= 1'b1;
          end
        end else if (w_clr[i]) begin
          r_pending[i] <= 1'b0;
          r_overrun[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_active = r_pending & ~mask;
    int_req  = |w_active;
    int_id   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        int_id = ID_BIT'(i);
      end
    end
  end

  assign level       = r_level;
  assign rise_pulse  = r_rise;
  assign int_pending = r_pending;
  assign int_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_aux_int_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_aux_int_input_conditioner
// Brief    : Scoreboard bench for aux_int_input_conditioner with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aux_int_input_conditioner;

  localparam int NUM_IN = 3;
  localparam int ID_BIT = 2;
  localparam int DEB    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_IN-1:0] raw_in;
  logic [NUM_IN-1:0] mask;
  logic              int_ack;
  logic [ID_BIT-1:0] int_ack_id;
  logic [NUM_IN-1:0] level;
  logic [NUM_IN-1:0] rise_pulse;
  logic [NUM_IN-1:0] int_pending;
  logic [NUM_IN-1:0] int_overrun;
  logic              int_req;
  logic [ID_BIT-1:0] int_id;

  aux_int_input_conditioner #(
    .NUM_IN(NUM_IN), .ID_BIT(ID_BIT), .DEBOUNCE_CNT(DEB), .CNT_BIT(3)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .mask(mask),
    .int_ack(int_ack), .int_ack_id(int_ack_id),
    .level(level), .rise_pulse(rise_pulse), .int_pending(int_pending),
    .int_overrun(int_overrun), .int_req(int_req), .int_id(int_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_IN-1:0] level;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] pend;
    logic [NUM_IN-1:0] ovr;
    logic              req;
    logic [ID_BIT-1:0] id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NUM_IN-1:0] m_level, m_rise, m_pend, m_ovr;
  logic [NUM_IN-1:0] m_dly[2];
  int                m_streak[NUM_IN];

  function automatic void model_reset();
    m_level = '0; m_rise = '0; m_pend = '0; m_ovr = '0;
    m_dly[0] = '0; m_dly[1] = '0;
    for (int c = 0; c < NUM_IN; c++) m_streak[c] = 0;
  endfunction

  function automatic void push_exp(input logic [NUM_IN-1:0] m);
    exp_t e;
    e.level = m_level; e.rise = m_rise; e.pend = m_pend; e.ovr = m_ovr;
    e.req = 1'b0; e.id = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (m_pend[c] && !m[c] && !e.req) begin
        e.req = 1'b1;
        e.id  = ID_BIT'(c);
      end
    end
    q.push_back(e);
  endfunction

  // One clock edge: the debouncer sees the input sampled two edges earlier and
  // flips after DEB consecutive samples that differ from the accepted level.
  function automatic void model_edge(input logic [NUM_IN-1:0] r, input logic a,
                                     input logic [ID_BIT-1:0] id, input logic rs);
    logic [NUM_IN-1:0] seen, n_rise, n_pend, n_ovr;
    logic clr;
    if (rs) begin
      model_reset();
      return;
    end
    seen = m_dly[0];
    m_dly[0] = m_dly[1];
    m_dly[1] = r;
    n_pend = m_pend; n_ovr = m_ovr; n_rise = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      clr = a && (int'(id) == c);
      if (m_rise[c]) begin
        if (m_pend[c] && !clr) n_ovr[c] = 1'b1;
        n_pend[c] = 1'b1;
      end else if (clr) begin
        n_pend[c] = 1'b0;
        n_ovr[c]  = 1'b0;
      end
      if (seen[c] == m_level[c]) begin
        m_streak[c] = 0;
      end else begin
        m_streak[c] = m_streak[c] + 1;
        if (m_streak[c] == DEB) begin
          m_level[c]  = seen[c];
          n_rise[c]   = seen[c];
          m_streak[c] = 0;
        end
      end
    end
    m_rise = n_rise; m_pend = n_pend; m_ovr = n_ovr;
  endfunction

  task automatic step(input logic [NUM_IN-1:0] r, input logic [NUM_IN-1:0] m,
                      input logic a, input logic [ID_BIT-1:0] id, input logic rs);
    raw_in = r; mask = m; int_ack = a; int_ack_id = id; rst = rs;
    @(posedge clk);
    model_edge(r, a, id, rs);
    push_exp(m);
    #3;
  endtask

  // Called 3 time units after a rising edge; pulses reset between edges.
  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    push_exp(mask);
    #2;
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a new output state after every edge and reset pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("level",       32'(level),       32'(e.level));
        chk("rise_pulse",  32'(rise_pulse),  32'(e.rise));
        chk("int_pending", 32'(int_pending), 32'(e.pend));
        chk("int_overrun", 32'(int_overrun), 32'(e.ovr));
        chk("int_req",     32'(int_req),     32'(e.req));
        chk("int_id",      32'(int_id),      32'(e.id));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_IN-1:0] r;
    logic [NUM_IN-1:0] m;
    model_reset();
    raw_in = '0; mask = '0; int_ack = 1'b0; int_ack_id = '0;

    // Reset held with all inputs high, then release
    repeat (3) step(3'b111, 3'b000, 1'b0, 2'd0, 1'b1);
    repeat (10) step(3'b111, 3'b000, 1'b0, 2'd0, 1'b0);

    // Priority and ack sequence
    step(3'b111, 3'b000, 1'b1, 2'd0, 1'b0);
    step(3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    step(3'b111, 3'b000, 1'b1, 2'd1, 1'b0);
    step(3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    step(3'b111, 3'b000, 1'b1, 2'd2, 1'b0);
    step(3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (10) step(3'b000, 3'b000, 1'b0, 2'd0, 1'b0);

    // Bouncing channel 1, then a steady hold
    for (int c = 0; c < 20; c++) begin
      r = 3'b000;
      r[1] = c[1];
      step(r, 3'b000, 1'b0, 2'd0, 1'b0);
    end
    repeat (12) step(3'b010, 3'b000, 1'b0, 2'd0, 1'b0);
    step(3'b010, 3'b000, 1'b1, 2'd1, 1'b0);
    repeat (10) step(3'b000, 3'b000, 1'b0, 2'd0, 1'b0);

    // Channel 0: first edge, second edge (overrun), third edge coinciding with ack
    repeat (8) step(3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (8) step(3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (8) step(3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (8) step(3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (8) step(3'b001, 3'b000, m_rise[0], 2'd0, 1'b0);
    step(3'b001, 3'b000, 1'b1, 2'd0, 1'b0);
    step(3'b001, 3'b000, 1'b0, 2'd0, 1'b0);

    // Masking and out-of-range ack
    repeat (8) step(3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (8) step(3'b001, 3'b001, 1'b0, 2'd0, 1'b0);
    step(3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
    step(3'b001, 3'b000, 1'b1, 2'd3, 1'b0);
    step(3'b001, 3'b000, 1'b1, 2'd0, 1'b0);

    // Asynchronous reset part-way through a debounce on channel 2
    repeat (4) step(3'b100, 3'b000, 1'b0, 2'd0, 1'b0);
    async_reset();
    repeat (10) step(3'b100, 3'b000, 1'b0, 2'd0, 1'b0);

    // Randomised traffic
    r = 3'b100;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NUM_IN; c++) begin
        if ($urandom_range(0, 7) == 0) r[c] = ~r[c];
      end
      m = NUM_IN'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) m = 3'b000;
      step(r, m, ($urandom_range(0, 2) == 0), ID_BIT'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    repeat (2) step(r, 3'b000, 1'b0, 2'd0, 1'b0);
    #5;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
